// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM frame-buffer arbiter: FSM encoding, address widths, wrap test.
// Pure declarations; no timing or flow control of its own.
package sdram_pkg;

   localparam int ADDR_W = 24;
   localparam int WORD_W = ADDR_W - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2
   } state_t;

   typedef enum logic {
      GNT_WR = 1'b0,
      GNT_RD = 1'b1
   } grant_t;

   // Compare on the pre-update address, widened to 24 bits so the sum cannot overflow.
   function automatic logic burst_wraps(input logic [WORD_W-1:0] word,
                                        input int unsigned burst_len,
                                        input int unsigned max_addr);
      logic [ADDR_W-1:0] sum;
      sum = {1'b0, word} + ADDR_W'(burst_len);
      return sum >= ADDR_W'(max_addr);
   endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Frame-buffer burst address counter with wrap and ping-pong bank select.
// Updates one cycle after advance/load; load has priority and never stalls.
module fb_addr_gen
   import sdram_pkg::*;
#(
   parameter int unsigned MAX_ADDR  = 786432,
   parameter int unsigned BURST_LEN = 512
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              advance,
   input  logic              load,
   input  logic              pingpang_en,
   input  logic              wrap_bank,
   output logic [ADDR_W-1:0] addr
);

   logic [WORD_W-1:0] word;
   logic              bank;

   assign addr = {bank, word};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word <= '0;
         bank <= 1'b0;
      end else if (load) begin
         word <= '0;
         bank <= 1'b0;
      end else begin
         if (advance) begin
            if (burst_wraps(word, BURST_LEN, MAX_ADDR)) begin
               word <= '0;
               bank <= pingpang_en & wrap_bank;
            end else begin
               word <= word + WORD_W'(BURST_LEN);
            end
         end
         // Without ping-pong the bank bit is pinned to 0, even if it was set earlier.
         if (!pingpang_en) begin
            bank <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sdram_fb_arbiter.sv
// Round-robin arbiter between camera writes and VGA reads into an SDRAM frame buffer.
// Grant is registered (request one cycle after the IDLE decision) and held until burst_done.
module sdram_fb_arbiter
   import sdram_pkg::*;
#(
   parameter int unsigned MAX_ADDR  = 786432,
   parameter int unsigned BURST_LEN = 512,
   parameter int          FIFO_W    = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sdram_init_done,
   input  logic [FIFO_W-1:0] wr_fifo_used,
   input  logic [FIFO_W-1:0] rd_fifo_used,
   input  logic              rd_valid,
   input  logic              pingpang_en,
   input  logic              wr_load,
   input  logic              rd_load,
   input  logic              burst_done,
   output logic              sdram_wr_req,
   output logic              sdram_rd_req,
   output logic [ADDR_W-1:0] sdram_wr_addr,
   output logic [ADDR_W-1:0] sdram_rd_addr,
   output logic              wr_frame_done
);

   state_t state;
   grant_t last_grant;
   logic   wr_pend;
   logic   rd_pend;
   logic   wr_adv;
   logic   rd_adv;

   assign wr_pend = 32'(wr_fifo_used) >= BURST_LEN;
   assign rd_pend = rd_valid && (32'(rd_fifo_used) < BURST_LEN);
   assign wr_adv  = (state == ST_WR) && burst_done;
   assign rd_adv  = (state == ST_RD) && burst_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         sdram_wr_req <= 1'b0;
         sdram_rd_req <= 1'b0;
         last_grant   <= GNT_RD;
      end else begin
         case (state)
            ST_IDLE: begin
               if (sdram_init_done && (wr_pend || rd_pend)) begin
                  if (wr_pend && (!rd_pend || last_grant == GNT_RD)) begin
                     state        <= ST_WR;
                     sdram_wr_req <= 1'b1;
                     last_grant   <= GNT_WR;
                  end else begin
                     state        <= ST_RD;
                     sdram_rd_req <= 1'b1;
                     last_grant   <= GNT_RD;
                  end
               end
            end
            ST_WR: begin
               if (burst_done) begin
                  state        <= ST_IDLE;
                  sdram_wr_req <= 1'b0;
               end
            end
            ST_RD: begin
               if (burst_done) begin
                  state        <= ST_IDLE;
                  sdram_rd_req <= 1'b0;
               end
            end
            default: begin
               state        <= ST_IDLE;
               sdram_wr_req <= 1'b0;
               sdram_rd_req <= 1'b0;
            end
         endcase
      end
   end

   // A load in the same cycle as the wrapping burst_done suppresses the frame pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_frame_done <= 1'b0;
      end else begin
         wr_frame_done <= wr_adv && !wr_load &&
                          burst_wraps(sdram_wr_addr[WORD_W-1:0], BURST_LEN, MAX_ADDR);
      end
   end

   fb_addr_gen #(
      .MAX_ADDR  (MAX_ADDR),
      .BURST_LEN (BURST_LEN)
   ) u_wr_addr (
      .clk         (clk),
      .rst_n       (rst_n),
      .advance     (wr_adv),
      .load        (wr_load),
      .pingpang_en (pingpang_en),
      .wrap_bank   (~sdram_wr_addr[ADDR_W-1]),
      .addr        (sdram_wr_addr)
   );

   // Reads always land on the bank the writer is not filling.
   fb_addr_gen #(
      .MAX_ADDR  (MAX_ADDR),
      .BURST_LEN (BURST_LEN)
   ) u_rd_addr (
      .clk         (clk),
      .rst_n       (rst_n),
      .advance     (rd_adv),
      .load        (rd_load),
      .pingpang_en (pingpang_en),
      .wrap_bank   (~sdram_wr_addr[ADDR_W-1]),
      .addr        (sdram_rd_addr)
   );

endmodule

// File: tb/tb_sdram_fb_arbiter.sv
// Directed, table-driven bench for sdram_fb_arbiter with hand-written wrap and reset sequences.
// Inputs change 1 time unit after posedge; outputs are compared at that same point.
module tb_sdram_fb_arbiter;

   localparam int FW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sdram_init_done;
   logic [FW-1:0] wr_fifo_used;
   logic [FW-1:0] rd_fifo_used;
   logic          rd_valid;
   logic          pingpang_en;
   logic          wr_load;
   logic          rd_load;
   logic          burst_done;
   logic          sdram_wr_req;
   logic          sdram_rd_req;
   logic [23:0]   sdram_wr_addr;
   logic [23:0]   sdram_rd_addr;
   logic          wr_frame_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sdram_fb_arbiter #(
      .MAX_ADDR  (786432),
      .BURST_LEN (512),
      .FIFO_W    (FW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sdram_init_done (sdram_init_done),
      .wr_fifo_used    (wr_fifo_used),
      .rd_fifo_used    (rd_fifo_used),
      .rd_valid        (rd_valid),
      .pingpang_en     (pingpang_en),
      .wr_load         (wr_load),
      .rd_load         (rd_load),
      .burst_done      (burst_done),
      .sdram_wr_req    (sdram_wr_req),
      .sdram_rd_req    (sdram_rd_req),
      .sdram_wr_addr   (sdram_wr_addr),
      .sdram_rd_addr   (sdram_rd_addr),
      .wr_frame_done   (wr_frame_done)
   );

   typedef struct {
      logic          init;
      logic [FW-1:0] wfu;
      logic [FW-1:0] rfu;
      logic          rdv;
      logic          pp;
      logic          wl;
      logic          rl;
      logic          bd;
      logic          exp_wreq;
      logic          exp_rreq;
      logic [23:0]   exp_waddr;
      logic [23:0]   exp_raddr;
      logic          exp_fd;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic init, input int wfu, input int rfu, input logic rdv,
                               input logic pp, input logic wl, input logic rl, input logic bd,
                               input logic ewr, input logic err, input int ewa, input int era,
                               input logic efd);
      vec_t v;
      v.init = init; v.wfu = FW'(wfu); v.rfu = FW'(rfu); v.rdv = rdv;
      v.pp = pp; v.wl = wl; v.rl = rl; v.bd = bd;
      v.exp_wreq = ewr; v.exp_rreq = err;
      v.exp_waddr = 24'(ewa); v.exp_raddr = 24'(era); v.exp_fd = efd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_fifo_used = '0;
      rd_fifo_used = '0;
      rd_valid     = 1'b0;
      wr_load      = 1'b0;
      rd_load      = 1'b0;
      burst_done   = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst wr_req",   24'(sdram_wr_req),  24'd0);
      chk("rst rd_req",   24'(sdram_rd_req),  24'd0);
      chk("rst wr_addr",  sdram_wr_addr,      24'd0);
      chk("rst rd_addr",  sdram_rd_addr,      24'd0);
      chk("rst frame_dn", 24'(wr_frame_done), 24'd0);
   endtask

   // One full burst: grant cycle, then burst_done; leaves the FSM in IDLE.
   task automatic burst(input bit is_wr);
      if (is_wr) begin
         wr_fifo_used = FW'(512);
         rd_valid     = 1'b0;
      end else begin
         wr_fifo_used = '0;
         rd_valid     = 1'b1;
         rd_fifo_used = '0;
      end
      burst_done = 1'b0;
      tick();
      burst_done = 1'b1;
      tick();
      idle_inputs();
   endtask

   initial begin
      rst_n           = 1'b0;
      sdram_init_done = 1'b0;
      pingpang_en     = 1'b0;
      idle_inputs();
      do_reset();

      //        init wfu  rfu rdv pp wl rl bd | wreq rreq waddr raddr fd
      vq.push_back(mk(0, 512,   0, 0, 0, 0, 0, 0,  0, 0,    0,    0, 0)); // init low blocks
      vq.push_back(mk(1, 512,   0, 0, 0, 0, 0, 0,  1, 0,    0,    0, 0)); // grant write
      vq.push_back(mk(1, 512,   0, 0, 0, 0, 0, 0,  1, 0,    0,    0, 0));
      vq.push_back(mk(1, 512,   0, 0, 0, 0, 0, 1,  0, 0,  512,    0, 0));
      vq.push_back(mk(1,   0,   0, 0, 0, 0, 0, 0,  0, 0,  512,    0, 0));
      vq.push_back(mk(1,   0,   0, 0, 0, 0, 0, 1,  0, 0,  512,    0, 0)); // bd in IDLE ignored
      vq.push_back(mk(1,   0,   0, 1, 0, 0, 0, 0,  0, 1,  512,    0, 0));
      vq.push_back(mk(1,   0,   0, 1, 0, 0, 0, 1,  0, 0,  512,  512, 0));
      vq.push_back(mk(1, 512,   0, 1, 0, 0, 0, 0,  1, 0,  512,  512, 0)); // contested: WR
      vq.push_back(mk(1, 512,   0, 1, 0, 0, 0, 1,  0, 0, 1024,  512, 0));
      vq.push_back(mk(1, 512,   0, 1, 0, 0, 0, 0,  0, 1, 1024,  512, 0)); // RD
      vq.push_back(mk(1, 512,   0, 1, 0, 0, 0, 1,  0, 0, 1024, 1024, 0));
      vq.push_back(mk(1, 512,   0, 1, 0, 0, 0, 0,  1, 0, 1024, 1024, 0)); // WR
      vq.push_back(mk(1, 512,   0, 1, 0, 0, 0, 1,  0, 0, 1536, 1024, 0));
      vq.push_back(mk(1, 512,   0, 1, 0, 0, 0, 0,  0, 1, 1536, 1024, 0)); // RD
      vq.push_back(mk(1, 512,   0, 1, 0, 0, 0, 1,  0, 0, 1536, 1536, 0));
      vq.push_back(mk(1, 511, 512, 1, 0, 0, 0, 0,  0, 0, 1536, 1536, 0)); // both just below threshold
      vq.push_back(mk(1,   0,   0, 0, 0, 0, 0, 0,  0, 0, 1536, 1536, 0)); // rd_valid low
      vq.push_back(mk(1, 512,   0, 0, 0, 0, 0, 0,  1, 0, 1536, 1536, 0));
      vq.push_back(mk(0, 512,   0, 0, 0, 0, 0, 0,  1, 0, 1536, 1536, 0)); // init drops mid-burst
      vq.push_back(mk(0, 512,   0, 0, 0, 0, 0, 1,  0, 0, 2048, 1536, 0));
      vq.push_back(mk(0, 512,   0, 0, 0, 0, 0, 0,  0, 0, 2048, 1536, 0));
      vq.push_back(mk(1, 512,   0, 0, 0, 0, 0, 0,  1, 0, 2048, 1536, 0));
      vq.push_back(mk(1, 512,   0, 0, 0, 1, 0, 0,  1, 0,    0, 1536, 0)); // load does not abort
      vq.push_back(mk(1, 512,   0, 0, 0, 0, 0, 1,  0, 0,  512, 1536, 0));
      vq.push_back(mk(1, 512,   0, 0, 0, 0, 0, 0,  1, 0,  512, 1536, 0));
      vq.push_back(mk(1, 512,   0, 0, 0, 0, 0, 1,  0, 0, 1024, 1536, 0));
      vq.push_back(mk(1, 512,   0, 0, 0, 0, 0, 0,  1, 0, 1024, 1536, 0));
      vq.push_back(mk(1, 512,   0, 0, 0, 1, 0, 1,  0, 0,    0, 1536, 0)); // load beats bd
      vq.push_back(mk(1,   0,   0, 0, 0, 0, 0, 0,  0, 0,    0, 1536, 0));
      vq.push_back(mk(1,   0,   0, 0, 0, 0, 1, 0,  0, 0,    0,    0, 0)); // rd_load
      vq.push_back(mk(1,   0, 511, 1, 0, 0, 0, 0,  0, 1,    0,    0, 0));
      vq.push_back(mk(1,   0, 511, 1, 0, 0, 0, 1,  0, 0,    0,  512, 0));

      for (int i = 0; i < vq.size(); i++) begin
         sdram_init_done = vq[i].init;
         wr_fifo_used    = vq[i].wfu;
         rd_fifo_used    = vq[i].rfu;
         rd_valid        = vq[i].rdv;
         pingpang_en     = vq[i].pp;
         wr_load         = vq[i].wl;
         rd_load         = vq[i].rl;
         burst_done      = vq[i].bd;
         tick();
         chk($sformatf("v%0d wr_req", i),   24'(sdram_wr_req),  24'(vq[i].exp_wreq));
         chk($sformatf("v%0d rd_req", i),   24'(sdram_rd_req),  24'(vq[i].exp_rreq));
         chk($sformatf("v%0d wr_addr", i),  sdram_wr_addr,      vq[i].exp_waddr);
         chk($sformatf("v%0d rd_addr", i),  sdram_rd_addr,      vq[i].exp_raddr);
         chk($sformatf("v%0d frame_dn", i), 24'(wr_frame_done), 24'(vq[i].exp_fd));
      end
      idle_inputs();

      // Ping-pong wraps: read wrap while writer on bank 0, write wrap, read wrap on bank 1.
      do_reset();
      sdram_init_done = 1'b1;
      pingpang_en     = 1'b1;
      for (int i = 0; i < 1535; i++) burst(1'b0);
      chk("rd pre-wrap addr", sdram_rd_addr, 24'd785920);
      burst(1'b0);
      chk("rd wrap wr_bank0", sdram_rd_addr, 24'h800000);

      for (int i = 0; i < 1535; i++) burst(1'b1);
      chk("wr pre-wrap addr", sdram_wr_addr, 24'd785920);
      chk("frame_dn pre",     24'(wr_frame_done), 24'd0);
      wr_fifo_used = FW'(512);
      tick();
      burst_done = 1'b1;
      tick();
      chk("wr wrap pp addr",  sdram_wr_addr,      24'h800000);
      chk("wr wrap pulse",    24'(wr_frame_done), 24'd1);
      idle_inputs();
      tick();
      chk("wr pulse width",   24'(wr_frame_done), 24'd0);
      chk("wr bank held",     sdram_wr_addr,      24'h800000);

      for (int i = 0; i < 1535; i++) burst(1'b0);
      chk("rd pre-wrap bank1", sdram_rd_addr, 24'h8BFE00);
      burst(1'b0);
      chk("rd wrap wr_bank1",  24'(sdram_rd_addr[23]), 24'd0);
      chk("rd wrap addr",      sdram_rd_addr,          24'd0);

      // Ping-pong off: bank bits cleared and stay 0 across a write wrap.
      pingpang_en = 1'b0;
      tick();
      chk("pp off wr bank", 24'(sdram_wr_addr[23]), 24'd0);
      chk("pp off rd bank", 24'(sdram_rd_addr[23]), 24'd0);
      for (int i = 0; i < 1535; i++) burst(1'b1);
      wr_fifo_used = FW'(512);
      tick();
      burst_done = 1'b1;
      tick();
      chk("wr wrap nopp addr",  sdram_wr_addr,      24'd0);
      chk("wr wrap nopp pulse", 24'(wr_frame_done), 24'd1);
      idle_inputs();
      for (int i = 0; i < 1536; i++) burst(1'b0);
      chk("rd wrap nopp addr", sdram_rd_addr, 24'd0);

      // Asynchronous reset in the middle of a write burst.
      burst(1'b1);
      chk("pre-arst wr_addr", sdram_wr_addr, 24'd512);
      wr_fifo_used = FW'(512);
      tick();
      chk("pre-arst wr_req", 24'(sdram_wr_req), 24'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst wr_req",  24'(sdram_wr_req), 24'd0);
      chk("arst wr_addr", sdram_wr_addr,     24'd0);
      tick();
      rst_n        = 1'b1;
      wr_fifo_used = '0;
      burst_done   = 1'b1;
      tick();
      chk("post-arst bd wr_addr", sdram_wr_addr,      24'd0);
      chk("post-arst bd wr_req",  24'(sdram_wr_req),  24'd0);
      chk("post-arst frame_dn",   24'(wr_frame_done), 24'd0);
      idle_inputs();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
